// File: rtl/ps2_mouse_receiver.sv
// PS/2 mouse receive path: pin conditioning, 11-bit frame deframing and
// 3-byte stream packet decode into movement bytes, direction flags and buttons.
module ps2_mouse_receiver #(
   parameter int FILTER_LEN     = 8,
   parameter int TIMEOUT_CYCLES = 200000,
   parameter int HOLD_CYCLES    = 1000000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       PS2Clk,
   input  logic       PS2Data,
   output logic [7:0] mouse_x,
   output logic [7:0] mouse_y,
   output logic       x_pos,
   output logic       x_neg,
   output logic       y_pos,
   output logic       y_neg,
   output logic       left,
   output logic       right
);

   localparam int FW = $clog2(FILTER_LEN + 1);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam int HW = $clog2(HOLD_CYCLES + 1);

   localparam logic [0:0] S_IDLE  = 1'b0;
   localparam logic [0:0] S_SHIFT = 1'b1;

   logic [1:0]    r_clk_sync, r_dat_sync;
   logic          r_clk_filt;
   logic [FW-1:0] r_filt_cnt;
   logic          r_fall, r_bit;
   logic          w_clk_s, w_dat_s;

   assign w_clk_s = r_clk_sync[1];
   assign w_dat_s = r_dat_sync[1];

   // Lines idle high, so reset the synchronizers high to avoid a false edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_clk_sync <= 2'b11;
         r_dat_sync <= 2'b11;
      end else begin
         r_clk_sync <= {r_clk_sync[0], PS2Clk};
         r_dat_sync <= {r_dat_sync[0], PS2Data};
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_clk_filt <= 1'b1;
         r_filt_cnt <= '0;
         r_fall     <= 1'b0;
         r_bit      <= 1'b1;
      end else begin
         r_fall <= 1'b0;
         r_bit  <= w_dat_s;
         if (w_clk_s == r_clk_filt) begin
            r_filt_cnt <= '0;
         end else if (r_filt_cnt == FW'(FILTER_LEN - 1)) begin
            r_clk_filt <= w_clk_s;
            r_filt_cnt <= '0;
            r_fall     <= ~w_clk_s;
         end else begin
            r_filt_cnt <= r_filt_cnt + 1'b1;
         end
      end
   end

   logic [0:0]    r_state;
   logic [3:0]    r_bitcnt;
   logic [9:0]    r_shift;
   logic [TW-1:0] r_tmo;
   logic          r_byte_stb, r_frame_drop;
   logic [7:0]    r_byte;
   logic [9:0]    w_frame;
   logic          w_frame_ok;

   // w_frame = {stop, parity, data[7:0]} once the tenth post-start bit arrives
   assign w_frame    = {r_bit, r_shift[9:1]};
   assign w_frame_ok = (^w_frame[8:0]) & w_frame[9];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state      <= S_IDLE;
         r_bitcnt     <= '0;
         r_shift      <= '0;
         r_tmo        <= '0;
         r_byte_stb   <= 1'b0;
         r_frame_drop <= 1'b0;
         r_byte       <= '0;
      end else begin
         r_byte_stb   <= 1'b0;
         r_frame_drop <= 1'b0;
         case (r_state)
            S_IDLE: begin
               r_tmo <= '0;
               if (r_fall && !r_bit) begin
                  r_state  <= S_SHIFT;
                  r_bitcnt <= '0;
               end
            end
            S_SHIFT: begin
               if (r_fall) begin
                  r_tmo    <= '0;
                  r_shift  <= w_frame;
                  r_bitcnt <= r_bitcnt + 1'b1;
                  if (r_bitcnt == 4'd9) begin
                     r_state <= S_IDLE;
                     if (w_frame_ok) begin
                        r_byte_stb <= 1'b1;
                        r_byte     <= w_frame[7:0];
                     end else begin
                        r_frame_drop <= 1'b1;
                     end
                  end
               end else if (r_tmo >= TW'(TIMEOUT_CYCLES)) begin
                  r_state      <= S_IDLE;
                  r_frame_drop <= 1'b1;
               end else begin
                  r_tmo <= r_tmo + 1'b1;
               end
            end
         endcase
      end
   end

   logic [1:0]    r_idx;
   logic [1:0]    r_btn;
   logic          r_xs, r_ys, r_xo, r_yo;
   logic [7:0]    r_b1;
   logic [7:0]    r_mx, r_my;
   logic          r_xp, r_xn, r_yp, r_yn, r_left, r_right;
   logic [HW-1:0] r_hold;
   logic          w_commit, w_x_mv, w_y_mv;

   assign w_commit = r_byte_stb && (r_idx == 2'd2);
   assign w_x_mv   = (r_b1 != 8'd0) | r_xo;
   assign w_y_mv   = (r_byte != 8'd0) | r_yo;

   // Byte 0 must carry the always-one bit 3, otherwise it is dropped to resync.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_idx <= '0;
         r_btn <= '0;
         r_xs  <= 1'b0;
         r_ys  <= 1'b0;
         r_xo  <= 1'b0;
         r_yo  <= 1'b0;
         r_b1  <= '0;
      end else if (r_frame_drop) begin
         r_idx <= '0;
      end else if (r_byte_stb) begin
         case (r_idx)
            2'd0: begin
               if (r_byte[3]) begin
                  r_btn <= r_byte[1:0];
                  r_xs  <= r_byte[4];
                  r_ys  <= r_byte[5];
                  r_xo  <= r_byte[6];
                  r_yo  <= r_byte[7];
                  r_idx <= 2'd1;
               end
            end
            2'd1: begin
               r_b1  <= r_byte;
               r_idx <= 2'd2;
            end
            default: r_idx <= 2'd0;
         endcase
      end
   end

   // Flags stay up for exactly HOLD_CYCLES after the latest commit.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_mx    <= '0;
         r_my    <= '0;
         r_xp    <= 1'b0;
         r_xn    <= 1'b0;
         r_yp    <= 1'b0;
         r_yn    <= 1'b0;
         r_left  <= 1'b0;
         r_right <= 1'b0;
         r_hold  <= '0;
      end else if (w_commit) begin
         r_mx    <= r_b1;
         r_my    <= r_byte;
         r_left  <= r_btn[0];
         r_right <= r_btn[1];
         r_xp    <= ~r_xs & w_x_mv;
         r_xn    <=  r_xs & w_x_mv;
         r_yp    <= ~r_ys & w_y_mv;
         r_yn    <=  r_ys & w_y_mv;
         r_hold  <= HW'(HOLD_CYCLES);
      end else if (r_hold != '0) begin
         r_hold <= r_hold - 1'b1;
         if (r_hold == HW'(1)) begin
            r_xp <= 1'b0;
            r_xn <= 1'b0;
            r_yp <= 1'b0;
            r_yn <= 1'b0;
         end
      end
   end

   assign mouse_x = r_mx;
   assign mouse_y = r_my;
   assign x_pos   = r_xp;
   assign x_neg   = r_xn;
   assign y_pos   = r_yp;
   assign y_neg   = r_yn;
   assign left    = r_left;
   assign right   = r_right;

endmodule

// File: tb/tb_ps2_mouse_receiver.sv
// Bench for ps2_mouse_receiver: PS/2 device driver, packet-level output model
// checked every cycle, plus literal expectations for each directed scenario.
module tb_ps2_mouse_receiver;

   localparam int FL   = 4;
   localparam int TO   = 2000;
   localparam int HD   = 5000;
   localparam int HALF = 30;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       PS2Clk = 1'b1;
   logic       PS2Data = 1'b1;
   logic [7:0] mouse_x, mouse_y;
   logic       x_pos, x_neg, y_pos, y_neg, left, right;

   always #5 clk = ~clk;

   ps2_mouse_receiver #(
      .FILTER_LEN(FL), .TIMEOUT_CYCLES(TO), .HOLD_CYCLES(HD)
   ) dut (
      .clk(clk), .reset(reset), .PS2Clk(PS2Clk), .PS2Data(PS2Data),
      .mouse_x(mouse_x), .mouse_y(mouse_y),
      .x_pos(x_pos), .x_neg(x_neg), .y_pos(y_pos), .y_neg(y_neg),
      .left(left), .right(right)
   );

   int n_vec = 0;
   int n_err = 0;
   int cyc   = 0;

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Model state: what the last committed packet says the outputs must be.
   logic [7:0] m_x = 8'h00, m_y = 8'h00;
   logic       m_l = 1'b0, m_r = 1'b0;
   logic       m_xp = 1'b0, m_xn = 1'b0, m_yp = 1'b0, m_yn = 1'b0;
   int         m_t = -100000;
   bit         settle = 1'b0;
   bit         chk_en = 1'b0;

   logic [21:0] c_got, c_exp, c_msk;
   logic [3:0]  c_flg;

   initial forever begin
      @(negedge clk);
      if (chk_en && !settle) begin
         c_got = {mouse_x, mouse_y, left, right, x_pos, x_neg, y_pos, y_neg};
         c_msk = '1;
         if (cyc < m_t + HD - 150) c_flg = {m_xp, m_xn, m_yp, m_yn};
         else c_flg = 4'b0000;
         if (cyc >= m_t + HD - 150 && cyc <= m_t + HD + 10) c_msk = 22'h3FFFF0;
         c_exp = {m_x, m_y, m_l, m_r, c_flg};
         n_vec++;
         if (((c_got ^ c_exp) & c_msk) != 22'h0) begin
            n_err++;
            if (n_err <= 20)
               $display("FAIL cycle_model cyc=%0d got=%h expected=%h", cyc, c_got, c_exp);
         end
      end
   end

   // x_pos high-time monitor for the hold checks.
   int   rise_c = 0, hi_len = 0, falls = 0;
   logic prev_xp = 1'b0;
   initial forever begin
      @(negedge clk);
      if (x_pos === 1'b1 && !prev_xp) rise_c = cyc;
      if (x_pos === 1'b0 && prev_xp) begin
         hi_len = cyc - rise_c;
         falls++;
      end
      prev_xp = (x_pos === 1'b1);
   end

   task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, got, exp);
      end
   endtask

   task automatic chk_int(input string nm, input int got, input int exp);
      n_vec++;
      if (got != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", nm, got, exp);
      end
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] b, input bit bad, input int nb);
      logic [10:0] fr;
      fr = {1'b1, (~^b) ^ bad, b, 1'b0};
      for (int i = 0; i < nb; i++) begin
         PS2Data = fr[i];
         wait_cyc(HALF);
         PS2Clk = 1'b0;
         wait_cyc(HALF);
         PS2Clk = 1'b1;
      end
      PS2Data = 1'b1;
      wait_cyc(2 * HALF);
   endtask

   task automatic model_commit(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
      bit xm, ym;
      xm   = (b1 != 0) || b0[6];
      ym   = (b2 != 0) || b0[7];
      m_x  = b1;
      m_y  = b2;
      m_l  = b0[0];
      m_r  = b0[1];
      m_xp = !b0[4] && xm;
      m_xn =  b0[4] && xm;
      m_yp = !b0[5] && ym;
      m_yn =  b0[5] && ym;
      m_t  = cyc;
   endtask

   task automatic send_packet(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
      send_frame(b0, 1'b0, 11);
      send_frame(b1, 1'b0, 11);
      settle = 1'b1;
      send_frame(b2, 1'b0, 11);
      model_commit(b0, b1, b2);
      settle = 1'b0;
   endtask

   int f0;

   initial begin
      wait_cyc(2);
      chk_en = 1'b1;
      for (int i = 0; i < 200; i++) begin
         PS2Clk  = 1'($urandom_range(1, 0));
         PS2Data = 1'($urandom_range(1, 0));
         wait_cyc(1);
      end
      PS2Clk  = 1'b1;
      PS2Data = 1'b1;
      wait_cyc(10);
      chk("reset mouse_x", mouse_x, 8'h00);
      chk("reset flags", {4'b0, x_pos, x_neg, y_pos, y_neg}, 8'h00);
      chk("reset buttons", {6'b0, left, right}, 8'h00);
      reset = 1'b0;
      wait_cyc(20);

      send_packet(8'h09, 8'h05, 8'hFB);
      chk("p1 left", left, 1'b1);
      chk("p1 right", right, 1'b0);
      chk("p1 mouse_x", mouse_x, 8'h05);
      chk("p1 x_pos", x_pos, 1'b1);
      chk("p1 mouse_y", mouse_y, 8'hFB);
      chk("p1 y_pos", y_pos, 1'b1);
      chk("p1 y_neg", y_neg, 1'b0);
      wait_cyc(100);

      send_packet(8'h3A, 8'hF0, 8'h10);
      chk("neg right", right, 1'b1);
      chk("neg left", left, 1'b0);
      chk("neg x_neg", x_neg, 1'b1);
      chk("neg x_pos", x_pos, 1'b0);
      chk("neg y_neg", y_neg, 1'b1);
      chk("neg mouse_x", mouse_x, 8'hF0);
      chk("neg mouse_y", mouse_y, 8'h10);
      wait_cyc(100);

      send_frame(8'h18, 1'b0, 11);
      send_frame(8'h7F, 1'b1, 11);
      send_frame(8'h33, 1'b0, 11);
      send_packet(8'h08, 8'h02, 8'h00);
      chk("par mouse_x", mouse_x, 8'h02);
      chk("par x_pos", x_pos, 1'b1);
      chk("par y flags", {y_pos, y_neg}, 8'h00);
      wait_cyc(100);

      // Short low glitch with data low: must not start a frame.
      PS2Data = 1'b0;
      wait_cyc(2);
      PS2Clk = 1'b0;
      wait_cyc(2);
      PS2Clk = 1'b1;
      wait_cyc(10);
      PS2Data = 1'b1;
      wait_cyc(50);
      send_frame(8'h00, 1'b0, 11);
      send_packet(8'h09, 8'h01, 8'h01);
      chk("resync left", left, 1'b1);
      chk("resync x_pos", x_pos, 1'b1);
      chk("resync y_pos", y_pos, 1'b1);
      wait_cyc(100);

      send_frame(8'h09, 1'b0, 11);
      send_frame(8'h55, 1'b0, 5);
      wait_cyc(TO + 200);
      send_packet(8'h08, 8'h04, 8'h00);
      chk("tmo mouse_x", mouse_x, 8'h04);
      chk("tmo x_pos", x_pos, 1'b1);
      chk("tmo y_pos", y_pos, 1'b0);

      wait_cyc(HD + 200);
      chk("expired x_pos", x_pos, 1'b0);
      f0 = falls;
      send_packet(8'h08, 8'h03, 8'h00);
      wait_cyc(HD + 300);
      chk_int("hold length", hi_len, HD);
      chk_int("hold single drop", falls - f0, 1);
      chk("hold mouse_x kept", mouse_x, 8'h03);
      chk("hold x_pos after", x_pos, 1'b0);

      f0 = falls;
      send_packet(8'h08, 8'h03, 8'h00);
      send_packet(8'h08, 8'h07, 8'h00);
      chk("refresh x_pos", x_pos, 1'b1);
      chk_int("refresh no drop", falls - f0, 0);
      wait_cyc(HD + 300);
      chk_int("refresh single drop", falls - f0, 1);
      chk_int("refresh continuous", int'(hi_len > HD + 1000), 1);
      chk("refresh mouse_x", mouse_x, 8'h07);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
